// File: rtl/mod_counter_bcd_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_bcd_pkg
//   Shared constants and types for the clock-digit counter family.
//   - Standard moduli for seconds, minutes and hours (24 h and 12 h).
//   - Default auto-repeat timing for a 50 MHz clock (used when the
//     HOLD_REPEAT_EN macro is defined in the counter).
//   - act_e: the single action a counter performs in a given cycle.
// -----------------------------------------------------------------------------
package mod_counter_bcd_pkg;

    localparam int MOD_SEC    = 60;
    localparam int MOD_MIN    = 60;
    localparam int MOD_HOUR   = 24;
    localparam int MOD_HOUR12 = 12;

    // 0.5 s before auto-repeat starts, then 5 steps per second at 50 MHz.
    localparam int DEF_REPEAT_DELAY  = 25_000_000;
    localparam int DEF_REPEAT_PERIOD = 10_000_000;

    // Width of the binary input of the BCD splitter (covers 0..99).
    localparam int BCD_BIN_W = 7;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_ADJ_UP,
        ACT_ADJ_DN,
        ACT_TICK
    } act_e;

endpackage

// File: rtl/mod_counter_bcd_bin2bcd2.sv
// -----------------------------------------------------------------------------
// bin2bcd2
//   Combinational split of a binary value 0..99 into two BCD digits.
//   Ports:
//     bin_i   in  7  binary value (0..99)
//     tens_o  out 4  bin_i / 10
//     ones_o  out 4  bin_i % 10
// -----------------------------------------------------------------------------
module bin2bcd2
    import mod_counter_bcd_pkg::*;
(
    input  logic [BCD_BIN_W-1:0] bin_i,
    output logic [3:0]           tens_o,
    output logic [3:0]           ones_o
);

    // Division by a constant; both quotient and remainder fit in 4 bits
    // for the legal input range.
    assign tens_o = 4'(bin_i / 7'd10);
    assign ones_o = 4'(bin_i % 7'd10);

endmodule

// File: rtl/mod_counter_bcd.sv
// -----------------------------------------------------------------------------
// mod_counter_bcd
//   Modulo-MODULUS clock digit (seconds / minutes / hours) with manual adjust.
//   Advances on a rising edge of the lower stage's carry level, can be stepped
//   up or down with a debounced button, and emits a one-cycle carry pulse when
//   a tick wraps MODULUS-1 -> 0. Adjust wraps never produce a carry.
//
//   Optional feature, macro HOLD_REPEAT_EN:
//     defined   - holding the button auto-repeats the adjust after REPEAT_DELAY
//                 cycles, then every REPEAT_PERIOD cycles until release.
//     undefined - exactly one adjust per press; REPEAT_* are only range-checked.
//
//   Ports:
//     clk50     in  1   system clock
//     reset     in  1   synchronous reset, active-low
//     tick_in   in  1   carry level from lower stage; rising edge = +1
//     hold      in  1   1: tick edges are dropped (adjust still works)
//     btn_n     in  1   adjust button, active-low, debounced
//     dir_up    in  1   1: adjust +1, 0: adjust -1
//     count     out CW  binary count, CW = $clog2(MODULUS)
//     bcd_tens  out 4   count / 10
//     bcd_ones  out 4   count % 10
//     carry_out out 1   registered one-cycle pulse on tick wrap
// -----------------------------------------------------------------------------
module mod_counter_bcd
    import mod_counter_bcd_pkg::*;
#(
    parameter int MODULUS       = MOD_HOUR,
    parameter int RESET_VALUE   = 0,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    localparam int CW           = (MODULUS > 2) ? $clog2(MODULUS) : 1
)
(
    input  logic          clk50,
    input  logic          reset,
    input  logic          tick_in,
    input  logic          hold,
    input  logic          btn_n,
    input  logic          dir_up,
    output logic [CW-1:0] count,
    output logic [3:0]    bcd_tens,
    output logic [3:0]    bcd_ones,
    output logic          carry_out
);

    localparam logic [CW-1:0] MAX_C = CW'(MODULUS - 1);
    localparam logic [CW-1:0] RST_C = CW'(RESET_VALUE);

    if (MODULUS < 2 || MODULUS > 100 || RESET_VALUE < 0 || RESET_VALUE >= MODULUS ||
        REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD - 1) begin : g_bad_params
        $error("mod_counter_bcd: illegal parameter combination");
    end

    logic [CW-1:0] count_q, count_d;
    logic          carry_q, carry_d;
    logic          tick_prev_q;
    logic          btn_prev_q;
    logic          tick_pend_q, tick_pend_d;
    logic          tick_edge, btn_edge, rep_fire;
    act_e          act;

    assign tick_edge = tick_in & ~tick_prev_q & ~hold;
    assign btn_edge  = ~btn_n & btn_prev_q;

`ifdef HOLD_REPEAT_EN
    localparam int RW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
    localparam logic [RW-1:0] REP_AT     = RW'(REPEAT_DELAY);
    // Reloading to DELAY-PERIOD+1 makes the next match exactly PERIOD cycles later.
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [RW-1:0] rep_q, rep_d;

    // rep_q holds the number of cycles since the press edge (0 on the edge cycle).
    always_comb begin
        rep_fire = 1'b0;
        rep_d    = rep_q;
        if (btn_n) begin
            rep_d = '0;
        end else if (rep_q == REP_AT) begin
            rep_fire = 1'b1;
            rep_d    = REP_RELOAD;
        end else begin
            rep_d = rep_q + RW'(1);
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Button (edge or repeat) outranks the tick; a tick seen alongside an
    // adjust is parked in tick_pend and served on the following cycle.
    always_comb begin
        act = ACT_NONE;
        if (btn_edge || rep_fire) begin
            act = dir_up ? ACT_ADJ_UP : ACT_ADJ_DN;
        end else if (tick_edge || tick_pend_q) begin
            act = ACT_TICK;
        end
    end

    always_comb begin
        count_d     = count_q;
        carry_d     = 1'b0;
        tick_pend_d = tick_pend_q;
        case (act)
            ACT_ADJ_UP: begin
                count_d     = (count_q >= MAX_C) ? '0 : count_q + CW'(1);
                tick_pend_d = tick_edge | tick_pend_q;
            end
            ACT_ADJ_DN: begin
                // An out-of-range value also steps down to the top of the range.
                count_d     = (count_q == '0 || count_q > MAX_C) ? MAX_C : count_q - CW'(1);
                tick_pend_d = tick_edge | tick_pend_q;
            end
            ACT_TICK: begin
                if (count_q >= MAX_C) begin
                    count_d = '0;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
                tick_pend_d = 1'b0;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk50) begin
        if (!reset) begin
            count_q     <= RST_C;
            carry_q     <= 1'b0;
            tick_prev_q <= 1'b0;
            btn_prev_q  <= 1'b1;
            tick_pend_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            carry_q     <= carry_d;
            tick_prev_q <= tick_in;
            btn_prev_q  <= btn_n;
            tick_pend_q <= tick_pend_d;
        end
    end

    assign count     = count_q;
    assign carry_out = carry_q;

    bin2bcd2 u_bcd (
        .bin_i  (BCD_BIN_W'(count_q)),
        .tens_o (bcd_tens),
        .ones_o (bcd_ones)
    );

endmodule
